ik_request_arbiter: RTL

Shares the single inverse-kinematics (IK) solver between two target sources: keyboard and ultrasonic tracker. Arbitrates valid/ready requests and latches and clamps the winning target. Issues a one-cycle start pulse to the IK solver, waits for its done pulse, then opens a servo-enable window so the servo PWM stages move only to a freshly solved pose. The block sits between the input decoders and the IK/PWM datapath.

---
 rtl/ik_request_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ik_request_arbiter.sv
// ik_request_arbiter: shares the single IK solver between the keyboard and
// ultrasonic target sources. Grants one valid/ready request at a time, latches
// the clamped target, pulses ik_start, waits for ik_done (with a timeout) and
// then opens a servo-enable settle window before accepting the next request.
module ik_request_arbiter #(
  parameter int COORD_W        = 8,
  parameter int MAX_X          = 15,
  parameter int MAX_Y          = 15,
  parameter int HOME_X         = 2,
  parameter int HOME_Y         = 2,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               kb_valid,
  input  logic [COORD_W-1:0] kb_x,
  input  logic [COORD_W-1:0] kb_y,
  output logic               kb_ready,
  input  logic               us_valid,
  input  logic [COORD_W-1:0] us_x,
  input  logic [COORD_W-1:0] us_y,
  output logic               us_ready,
  output logic               ik_start,
  output logic [COORD_W-1:0] ik_x,
  output logic [COORD_W-1:0] ik_y,
  input  logic               ik_done,
  output logic               servo_en,
  output logic [1:0]         owner,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    SETTLE
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_KB   = 2'b01;
  localparam logic [1:0] OWN_US   = 2'b10;

  localparam int TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SET_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [TMR_W-1:0]    TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0]    SET_LOAD    = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(STARVE_LIMIT);
  localparam logic [COORD_W-1:0]  MAX_X_C     = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0]  MAX_Y_C     = COORD_W'(MAX_Y);
  localparam logic [COORD_W-1:0]  HOME_X_C    = COORD_W'(HOME_X);
  localparam logic [COORD_W-1:0]  HOME_Y_C    = COORD_W'(HOME_Y);

  state_e              state_q, state_d;
  logic                ik_start_q, ik_start_d;
  logic                servo_en_q, servo_en_d;
  logic [1:0]          owner_q, owner_d;
  logic                terr_q, terr_d;
  logic [COORD_W-1:0]  ik_x_q, ik_x_d;
  logic [COORD_W-1:0]  ik_y_q, ik_y_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic us_win;
  logic in_idle;

  // Unsigned clamp of a requested coordinate to its legal maximum.
  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                               input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Combinational grant: keyboard first unless the ultrasonic source is starved.
  always_comb begin
    us_win   = us_valid && (!kb_valid || (streak_q == STREAK_MAX));
    in_idle  = (state_q == IDLE) && !reset;
    us_ready = in_idle && us_win;
    kb_ready = in_idle && kb_valid && !us_win;
  end

  // Next-state and next-output computation for the request/solve/settle sequence.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned
    // and no latch is inferred.
    state_d    = state_q;
    ik_start_d = 1'b0;
    servo_en_d = servo_en_q;
    owner_d    = owner_q;
    terr_d     = terr_q;
    ik_x_d     = ik_x_q;
    ik_y_d     = ik_y_q;
    tmr_d      = tmr_q;
    settle_d   = settle_q;
    streak_d   = streak_q;

    case (state_q)
      IDLE: begin
        if (us_ready) begin
          ik_x_d     = clamp(us_x, MAX_X_C);
          ik_y_d     = clamp(us_y, MAX_Y_C);
          owner_d    = OWN_US;
          streak_d   = '0;
          ik_start_d = 1'b1;
          state_d    = ISSUE;
        end else if (kb_ready) begin
          ik_x_d     = clamp(kb_x, MAX_X_C);
          ik_y_d     = clamp(kb_y, MAX_Y_C);
          owner_d    = OWN_KB;
          ik_start_d = 1'b1;
          state_d    = ISSUE;
          if (us_valid) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
          end else begin
            streak_d = '0;
          end
        end
      end
      ISSUE: begin
        // ik_done is deliberately not looked at while the start pulse is out.
        tmr_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ik_done) begin
          settle_d   = SET_LOAD;
          servo_en_d = 1'b1;
          state_d    = SETTLE;
        end else if (tmr_q == TMR_LAST) begin
          terr_d  = 1'b1;
          owner_d = OWN_NONE;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          servo_en_d = 1'b0;
          owner_d    = OWN_NONE;
          state_d    = IDLE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset aborts any operation at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      ik_start_q <= 1'b0;
      servo_en_q <= 1'b0;
      owner_q    <= OWN_NONE;
      terr_q     <= 1'b0;
      ik_x_q     <= HOME_X_C;
      ik_y_q     <= HOME_Y_C;
      tmr_q      <= '0;
      settle_q   <= '0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      ik_start_q <= ik_start_d;
      servo_en_q <= servo_en_d;
      owner_q    <= owner_d;
      terr_q     <= terr_d;
      ik_x_q     <= ik_x_d;
      ik_y_q     <= ik_y_d;
      tmr_q      <= tmr_d;
      settle_q   <= settle_d;
      streak_q   <= streak_d;
    end
  end

  assign ik_start    = ik_start_q;
  assign servo_en    = servo_en_q;
  assign owner       = owner_q;
  assign timeout_err = terr_q;
  assign ik_x        = ik_x_q;
  assign ik_y        = ik_y_q;

endmodule
